// File: rtl/alu_pkg.sv
// Shared constants and the issue-entry struct for the ALU decode/issue stage.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_SHL = 4'd2;
   localparam logic [3:0] ALU_SHR = 4'd3;
   localparam logic [3:0] ALU_NOT = 4'd4;
   localparam logic [3:0] ALU_AND = 4'd5;
   localparam logic [3:0] ALU_OR  = 4'd6;
   localparam logic [3:0] ALU_XOR = 4'd7;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] operand0;
      logic [31:0] operand1;
      logic [4:0]  rd;
      logic        wb;
      logic        illegal;
   } alu_issue_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode into an ALU issue entry; unsupported encodings
// come out flagged illegal with zero op/operands and no write-back.
module alu_issue_decode
   import alu_pkg::*;
(
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_rs1_data,
   input  logic [31:0] i_rs2_data,
   output logic [4:0]  o_rs1_addr,
   output logic [4:0]  o_rs2_addr,
   output alu_issue_t  o_issue
);

   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [4:0]  w_rd;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_u;
   logic [31:0] w_shamt;
   logic [3:0]  w_op;
   logic [31:0] w_opnd0;
   logic [31:0] w_opnd1;
   logic        w_legal;

   assign w_opcode   = i_instr[6:0];
   assign w_rd       = i_instr[11:7];
   assign w_f3       = i_instr[14:12];
   assign w_f7       = i_instr[31:25];
   assign o_rs1_addr = i_instr[19:15];
   assign o_rs2_addr = i_instr[24:20];
   assign w_imm_i    = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_imm_u    = {i_instr[31:12], 12'b0};
   assign w_shamt    = {27'b0, i_instr[24:20]};

   always_comb begin
      w_op    = ALU_ADD;
      w_opnd0 = i_rs1_data;
      w_opnd1 = i_rs2_data;
      w_legal = 1'b0;
      case (w_opcode)
         OPC_OP: begin
            case (w_f3)
               F3_ADD_SUB: begin
                  w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
                  w_op    = (w_f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
               end
               F3_SLL:     begin w_op = ALU_SHL; w_legal = (w_f7 == F7_ZERO); end
               F3_XOR:     begin w_op = ALU_XOR; w_legal = (w_f7 == F7_ZERO); end
               F3_SRL_SRA: begin w_op = ALU_SHR; w_legal = (w_f7 == F7_ZERO); end
               F3_OR:      begin w_op = ALU_OR;  w_legal = (w_f7 == F7_ZERO); end
               F3_AND:     begin w_op = ALU_AND; w_legal = (w_f7 == F7_ZERO); end
               default:    w_legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            w_opnd1 = w_imm_i;
            case (w_f3)
               F3_ADD_SUB: begin w_op = ALU_ADD; w_legal = 1'b1; end
               F3_XOR:     begin w_op = ALU_XOR; w_legal = 1'b1; end
               F3_OR:      begin w_op = ALU_OR;  w_legal = 1'b1; end
               F3_AND:     begin w_op = ALU_AND; w_legal = 1'b1; end
               F3_SLL: begin
                  w_op    = ALU_SHL;
                  w_opnd1 = w_shamt;
                  w_legal = (w_f7 == F7_ZERO);
               end
               F3_SRL_SRA: begin
                  w_op    = ALU_SHR;
                  w_opnd1 = w_shamt;
                  w_legal = (w_f7 == F7_ZERO);
               end
               default: w_legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            w_opnd0 = '0;
            w_opnd1 = w_imm_u;
            w_legal = 1'b1;
         end
         OPC_AUIPC: begin
            w_opnd0 = i_pc;
            w_opnd1 = w_imm_u;
            w_legal = 1'b1;
         end
         default: w_legal = 1'b0;
      endcase
   end

   always_comb begin
      o_issue         = '0;
      o_issue.rd      = w_rd;
      o_issue.illegal = !w_legal;
      o_issue.wb      = w_legal && (w_rd != 5'd0);
      if (w_legal) begin
         o_issue.op       = w_op;
         o_issue.operand0 = w_opnd0;
         o_issue.operand1 = w_opnd1;
      end
   end

endmodule

// File: rtl/alu_issue.sv
// RV32I decode/issue stage feeding the integer ALU from a registered output.
// ALU_ISSUE_SKID_EN selects a 2-entry skid buffer with a registered in_ready.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid low
// ST_ONE   | main register holds the issued entry
// ST_TWO   | main issued, skid holds the next entry, in_ready low
module alu_issue
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [XLEN-1:0] i_in_instr,
   input  logic [XLEN-1:0] i_in_pc,
   output logic [4:0]      o_rs1_addr,
   output logic [4:0]      o_rs2_addr,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [3:0]      o_out_op,
   output logic [XLEN-1:0] o_out_operand0,
   output logic [XLEN-1:0] o_out_operand1,
   output logic [4:0]      o_out_rd,
   output logic            o_out_wb,
   output logic            o_out_illegal
);

   alu_issue_t w_dec;
   alu_issue_t r_main;
   logic       r_out_valid;
   logic       w_accept;
   logic       w_drain;

   alu_issue_decode u_decode (
      .i_instr    (i_in_instr),
      .i_pc       (i_in_pc),
      .i_rs1_data (i_rs1_data),
      .i_rs2_data (i_rs2_data),
      .o_rs1_addr (o_rs1_addr),
      .o_rs2_addr (o_rs2_addr),
      .o_issue    (w_dec)
   );

   assign w_drain = r_out_valid && i_out_ready;

`ifdef ALU_ISSUE_SKID_EN
   skid_state_e r_state;
   alu_issue_t  r_skid;
   logic        r_in_ready;

   assign o_in_ready = r_in_ready;
   assign w_accept   = i_in_valid && r_in_ready;

   // in_ready is updated in each branch to the value (next state != TWO)
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_main      <= '0;
         r_skid      <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_main      <= w_dec;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && w_drain) begin
                  r_main <= w_dec;
               end else if (w_drain) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_EMPTY;
               end else if (w_accept) begin
                  r_skid     <= w_dec;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_TWO;
               end
            end
            ST_TWO: begin
               if (w_drain) begin
                  r_main     <= r_skid;
                  r_in_ready <= 1'b1;
                  r_state    <= ST_ONE;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end
`else
   assign o_in_ready = !r_out_valid || i_out_ready;
   assign w_accept   = i_in_valid && o_in_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_out_valid <= 1'b0;
         r_main      <= '0;
      end else if (w_accept) begin
         r_main      <= w_dec;
         r_out_valid <= 1'b1;
      end else if (w_drain) begin
         r_out_valid <= 1'b0;
      end
   end
`endif

   assign o_out_valid    = r_out_valid;
   assign o_out_op       = r_main.op;
   assign o_out_operand0 = r_main.operand0;
   assign o_out_operand1 = r_main.operand1;
   assign o_out_rd       = r_main.rd;
   assign o_out_wb       = r_main.wb;
   assign o_out_illegal  = r_main.illegal;

endmodule
